// File: rtl/icap_ctrl_pkg.sv
// Shared types for the ICAP stream writer: controller states, error codes,
// and the per-byte bit-reversal helper used when bit swapping is enabled.
package icap_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WAIT_DONE = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PRERROR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Reverse the bit order inside one byte (bit 0 <-> bit 7).
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k] = b[7-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_bitswap.sv
// Combinational byte-wise bit reversal of a bitstream word, matching the bit
// order of Xilinx .bit files. Any bits beyond the last whole byte pass through.
module icap_bitswap
  import icap_ctrl_pkg::*;
#(
  parameter int C_I_WIDTH = 32
) (
  input  logic [C_I_WIDTH-1:0] data_i,
  output logic [C_I_WIDTH-1:0] data_o
);

  localparam int C_BYTES = C_I_WIDTH / 8;

  genvar g;
  for (g = 0; g < C_BYTES; g++) begin : g_byte
    assign data_o[8*g +: 8] = bitrev8(data_i[8*g +: 8]);
  end

  if ((C_I_WIDTH % 8) != 0) begin : g_rem
    assign data_o[C_I_WIDTH-1:C_BYTES*8] = data_i[C_I_WIDTH-1:C_BYTES*8];
  end

endmodule

// File: rtl/icap_stream_writer.sv
// Write-only ICAP controller: takes a partial bitstream from an AXI4-Stream
// slave, writes it to ICAP under m_avail backpressure, then waits for
// prdone/prerror (with timeout) and reports sticky done/error status.
// Optional feature macro: ICAP_BITSWAP_EN bit-reverses each byte of tdata.
module icap_stream_writer
  import icap_ctrl_pkg::*;
#(
  parameter int C_I_WIDTH      = 32,
  parameter int C_DONE_TIMEOUT = 4096,
  parameter int C_CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [C_I_WIDTH-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   m_csib,
  output logic                   m_rdwrb,
  output logic [C_I_WIDTH-1:0]   m_i,
  input  logic [C_I_WIDTH-1:0]   m_o,
  output logic                   m_clk,
  input  logic                   m_avail,
  input  logic                   m_prdone,
  input  logic                   m_prerror,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [C_CNT_WIDTH-1:0] word_count
);

  localparam int C_TMO_WIDTH = $clog2(C_DONE_TIMEOUT + 1);
  localparam logic [C_TMO_WIDTH-1:0] C_TMO_LIMIT = C_TMO_WIDTH'(C_DONE_TIMEOUT);

  state_e                 state_q, state_d;
  logic                   csib_q, csib_d;
  logic                   rdwrb_q, rdwrb_d;
  logic [C_I_WIDTH-1:0]   i_q, i_d;
  logic [1:0]             err_q, err_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic [C_TMO_WIDTH-1:0] tmo_inc_s;
  logic [C_I_WIDTH-1:0]   swap_s;
  logic                   accept_s;
  logic                   m_o_unused;

  // Readback is never used by a write-only controller.
  assign m_o_unused = ^m_o;

`ifdef ICAP_BITSWAP_EN
  icap_bitswap #(.C_I_WIDTH(C_I_WIDTH)) u_bitswap (
    .data_i (s_axis_tdata),
    .data_o (swap_s)
  );
`else
  assign swap_s = s_axis_tdata;
`endif

  assign m_clk         = clk;
  assign s_axis_tready = (state_q == WRITE) && m_avail;
  assign accept_s      = s_axis_tready && s_axis_tvalid;
  assign tmo_inc_s     = tmo_q + C_TMO_WIDTH'(1);

  assign m_csib     = csib_q;
  assign m_rdwrb    = rdwrb_q;
  assign m_i        = i_q;
  assign busy       = (state_q == WRITE) || (state_q == WAIT_DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign err_code   = err_q;
  assign word_count = cnt_q;

  // Next-state, counters and next ICAP pin values.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    i_d     = i_q;
    csib_d  = 1'b1;

    // The accepted word is presented to ICAP next cycle, even if the state
    // leaves WRITE in the same cycle (tlast or prerror).
    if (accept_s) begin
      i_d    = swap_s;
      csib_d = 1'b0;
      if (~&cnt_q) begin
        cnt_d = cnt_q + C_CNT_WIDTH'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      i_d = i_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = {C_CNT_WIDTH{1'b0}};
          err_d   = ERR_NONE;
          tmo_d   = {C_TMO_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (m_prerror) begin
          state_d = ERROR;
          err_d   = ERR_PRERROR;
        end else if (accept_s && s_axis_tlast) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WRITE;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_inc_s;
        if (m_prerror) begin
          state_d = ERROR;
          err_d   = ERR_PRERROR;
        end else if (m_prdone) begin
          state_d = DONE;
        end else if (tmo_inc_s == C_TMO_LIMIT) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      DONE, ERROR: begin
        if (clear) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Write direction is held for the whole transfer and for the final
    // in-flight word; otherwise ICAP idles in read direction.
    rdwrb_d = ~(accept_s || (state_d == WRITE) || (state_d == WAIT_DONE));
  end

  // State and registered ICAP outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b1;
      i_q     <= {C_I_WIDTH{1'b0}};
      err_q   <= ERR_NONE;
      cnt_q   <= {C_CNT_WIDTH{1'b0}};
      tmo_q   <= {C_TMO_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      i_q     <= i_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_icap_stream_writer.sv
// Directed testbench for icap_stream_writer: basic transfer, backpressure,
// bit swap, prerror, timeout, reset and ignored control pulses.
module tb_icap_stream_writer;

  localparam int W  = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, start, clear;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_csib, m_rdwrb, m_clk, m_avail, m_prdone, m_prerror;
  logic [W-1:0]  m_i, m_o;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [CW-1:0] word_count;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  logic [31:0] basic_w [4] = '{32'hAA995566, 32'h20000000, 32'h30008001, 32'h0000000D};
  logic [31:0] bp_w    [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                               32'h44444444, 32'h55555555, 32'h66666666};

`ifdef ICAP_BITSWAP_EN
  localparam logic [31:0] SWAP_EXP = 32'h80010204;
`else
  localparam logic [31:0] SWAP_EXP = 32'h01804020;
`endif

  always #5 clk = ~clk;

  icap_stream_writer #(
    .C_I_WIDTH      (W),
    .C_DONE_TIMEOUT (16),
    .C_CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clear         (clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_csib        (m_csib),
    .m_rdwrb       (m_rdwrb),
    .m_i           (m_i),
    .m_o           (m_o),
    .m_clk         (m_clk),
    .m_avail       (m_avail),
    .m_prdone      (m_prdone),
    .m_prerror     (m_prerror),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .word_count    (word_count)
  );

  // Expected ICAP data for a stream word.
  function automatic logic [31:0] exp_i(input logic [31:0] d);
    logic [31:0] r;
`ifdef ICAP_BITSWAP_EN
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*b + k] = d[8*b + 7 - k];
      end
    end
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_o = '0; m_avail = 1'b1; m_prdone = 1'b0; m_prerror = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_csib", m_csib, 1);
    chk("rst_rdwrb", m_rdwrb, 1);
    chk("rst_m_i", m_i, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_word_count", word_count, 0);
    chk("m_clk_follows", m_clk, clk);
    s_axis_tvalid = 1'b1;
    settle();
    chk("idle_tready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;

    // Basic transfer
    start = 1'b1; tick(); start = 1'b0;
    chk("bas_busy", busy, 1);
    chk("bas_rdwrb_low", m_rdwrb, 0);
    chk("bas_csib_idle", m_csib, 1);
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = basic_w[i]; s_axis_tlast = (i == 3);
      settle();
      chk("bas_tready", s_axis_tready, 1);
      tick();
      chk("bas_m_i", m_i, exp_i(basic_w[i]));
      chk("bas_csib", m_csib, 0);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    chk("bas_wait_csib", m_csib, 1);
    chk("bas_wait_busy", busy, 1);
    chk("bas_wait_rdwrb", m_rdwrb, 0);
    repeat (3) tick();
    chk("bas_not_done_yet", done, 0);
    m_prdone = 1'b1; tick(); m_prdone = 1'b0;
    chk("bas_done", done, 1);
    chk("bas_busy_off", busy, 0);
    chk("bas_count", word_count, 4);
    chk("bas_err_code", err_code, 0);
    chk("bas_done_rdwrb", m_rdwrb, 1);
    chk("bas_done_csib", m_csib, 1);

    // start in DONE ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("ign_start_done", done, 1);
    chk("ign_start_busy", busy, 0);
    chk("ign_start_count", word_count, 4);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_done", done, 0);
    chk("clr_error", error, 0);
    chk("clr_busy", busy, 0);

    // Backpressure: m_avail low for 3 cycles before word 2
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        m_avail = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = bp_w[2]; s_axis_tlast = 1'b0;
        for (int s = 0; s < 3; s++) begin
          settle();
          chk("bp_stall_tready", s_axis_tready, 0);
          tick();
          chk("bp_stall_csib", m_csib, 1);
          chk("bp_stall_hold", m_i, exp_i(bp_w[1]));
        end
        m_avail = 1'b1;
      end
      s_axis_tvalid = 1'b1; s_axis_tdata = bp_w[i]; s_axis_tlast = (i == 5);
      settle();
      chk("bp_tready", s_axis_tready, 1);
      tick();
      chk("bp_m_i", m_i, exp_i(bp_w[i]));
      chk("bp_csib", m_csib, 0);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    m_prdone = 1'b1; tick(); m_prdone = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_count", word_count, 6);
    clear = 1'b1; tick(); clear = 1'b0;

    // Bit swap (or identity in the default build)
    start = 1'b1; tick(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h01804020; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("swap_m_i", m_i, SWAP_EXP);
    m_prdone = 1'b1; tick(); m_prdone = 1'b0;
    chk("swap_done", done, 1);
    clear = 1'b1; tick(); clear = 1'b0;

    // Prerror after word 2
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = basic_w[i]; s_axis_tlast = 1'b0;
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_prerror = 1'b1; tick(); m_prerror = 1'b0;
    chk("pe_error", error, 1);
    chk("pe_err_code", err_code, 1);
    chk("pe_busy", busy, 0);
    chk("pe_count", word_count, 2);
    chk("pe_rdwrb", m_rdwrb, 1);
    s_axis_tvalid = 1'b1;
    settle();
    chk("pe_tready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    tick();
    chk("pe_sticky", error, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("pe_clr_error", error, 0);
    chk("pe_clr_done", done, 0);
    chk("pe_clr_busy", busy, 0);

    // Timeout: prdone never arrives
    start = 1'b1; tick(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hCAFEF00D; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", error, 0);
    chk("to_busy", busy, 1);
    tick();
    chk("to_error", error, 1);
    chk("to_err_code", err_code, 2);
    clear = 1'b1; tick(); clear = 1'b0;

    // Reset mid-WRITE
    start = 1'b1; tick(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h12345678; s_axis_tlast = 1'b0;
    tick();
    chk("mr_csib_active", m_csib, 0);
    rst = 1'b1;
    settle();
    chk("mr_csib", m_csib, 1);
    chk("mr_rdwrb", m_rdwrb, 1);
    chk("mr_busy", busy, 0);
    chk("mr_m_i", m_i, 0);
    chk("mr_count", word_count, 0);
    s_axis_tvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // start while busy ignored
    start = 1'b1; tick(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5A5A5A5; s_axis_tlast = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_count", word_count, 1);
    chk("busy_start_busy", busy, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h5A5A5A5A; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_prdone = 1'b1; tick(); m_prdone = 1'b0;
    chk("busy_start_done", done, 1);
    chk("busy_start_total", word_count, 2);
    clear = 1'b1; tick(); clear = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/icap_stream_writer.md
# icap_stream_writer

Write-only ICAP controller that sits directly upstream of the ICAP wirethrough stub. It accepts a partial-bitstream word stream on an AXI4-Stream slave and drives the ICAP master signals (csib, rdwrb, i, clk) while honouring avail backpressure. It then waits for prdone/prerror and reports a sticky done/error status to the control plane.

## Interface
- C_I_WIDTH, 32: ICAP data width; also the stream data width.
- C_DONE_TIMEOUT, 4096: maximum cycles to wait for m_prdone after the last word; valid range 1 to 2^20.
- C_CNT_WIDTH, 32: width of the accepted-word counter.

Ports:
- clk  in  1  single clock for all logic; also forwarded as m_clk.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- clear  in  1  one-cycle pulse; returns DONE or ERROR to IDLE.
- s_axis_tdata  in  C_I_WIDTH  bitstream word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  word accepted when tvalid and tready are both high.
- s_axis_tlast  in  1  marks the final bitstream word.
- m_csib  out  1  ICAP chip select, active-low.
- m_rdwrb  out  1  ICAP direction; 0 means write.
- m_i  out  C_I_WIDTH  ICAP write data.
- m_o  in  C_I_WIDTH  ICAP readback data; unused.
- m_clk  out  1  equal to clk, combinational.
- m_avail  in  1  ICAP ready to accept a write.
- m_prdone  in  1  ICAP reports partial reconfiguration complete.
- m_prerror  in  1  ICAP reports a reconfiguration error.
- busy  out  1  high in WRITE and WAIT_DONE.
- done  out  1  sticky; high in DONE.
- error  out  1  sticky; high in ERROR.
- err_code  out  2  0 = none, 1 = prerror, 2 = timeout.
- word_count  out  C_CNT_WIDTH  words accepted since the last start; saturates at all-ones.

## Operation
- States: IDLE, WRITE, WAIT_DONE, DONE, ERROR.
- IDLE, on start: go to WRITE, clear word_count, err_code and the timeout counter.
- WRITE:
  - s_axis_tready = m_avail (combinational).
  - Each accepted word: next cycle m_csib=0, m_rdwrb=0, m_i=swap(tdata); word_count +1.
  - Cycle with no accept: m_csib=1; m_i holds its last value; m_rdwrb stays 0.
  - Accepted word with tlast=1: go to WAIT_DONE.
- WAIT_DONE:
  - m_csib=1; timeout counter increments each cycle.
  - m_prdone=1: go to DONE.
  - Counter reaches C_DONE_TIMEOUT: go to ERROR with err_code=2.
- m_prerror=1 in WRITE or WAIT_DONE: go to ERROR with err_code=1. This has priority over prdone, tlast and timeout in the same cycle; the word in flight is still presented to ICAP.
- DONE and ERROR: m_csib=1, m_rdwrb=1, tready=0. Only clear leaves; start is ignored.
- start outside IDLE is ignored. clear outside DONE/ERROR is ignored.
- swap() is the identity unless the Configuration macro is defined.

## Timing
- Reset values: m_csib=1, m_rdwrb=1, m_i=0, busy=0, done=0, error=0, err_code=0, word_count=0, state=IDLE. s_axis_tready=0 because it is gated by state.
- Latency from tdata to m_i is 1 cycle. m_csib, m_rdwrb and m_i are all registered.
- m_avail low stalls via tready in the same cycle; no skid buffer is needed.
- m_rdwrb goes 1→0 on the cycle after start and stays 0 until WRITE/WAIT_DONE is left.
- rst mid-transfer returns all outputs to reset values immediately. The in-flight word is lost and ICAP sees csib rise asynchronously.
- done/error assert the cycle after the triggering event.

## Configuration
- ICAP_BITSWAP_EN defined: m_i is each byte of tdata bit-reversed in place (bit 0↔7 within each byte), for Xilinx .bit byte order.
- ICAP_BITSWAP_EN undefined: m_i equals tdata unchanged.

## Structure
- Package icap_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, WAIT_DONE, DONE, ERROR);
  - err_code constants ERR_NONE=0, ERR_PRERROR=1, ERR_TIMEOUT=2;
  - the bit-swap function.
- One sub-module: icap_bitswap (combinational, parameterised by C_I_WIDTH), instantiated only under ICAP_BITSWAP_EN.

## Test plan
- Basic transfer: start, 4 words 0xAA995566, 0x20000000, 0x30008001, 0x0000000D (last), avail=1, prdone 5 cycles later:
  - m_i shows the 4 words on consecutive cycles with m_csib=0;
  - done=1, word_count=4, err_code=0.
- Backpressure: m_avail low for 3 cycles mid-stream:
  - tready=0 and m_csib=1 during the stall;
  - no word dropped or duplicated; word_count equals words sent.
- Bitswap: with ICAP_BITSWAP_EN, tdata 0x01804020 → m_i 0x80010204; without the macro, m_i=0x01804020.
- Prerror: prerror pulses after word 2 → error=1, err_code=1, tready=0. Then clear → IDLE with done=0, error=0.
- Timeout: C_DONE_TIMEOUT=16, prdone never asserted → error at cycle 16 after the last word, err_code=2.
- Reset and ignored pulses:
  - rst asserted mid-WRITE → m_csib=1, m_rdwrb=1, busy=0 immediately;
  - start while busy is ignored;
  - start after DONE without clear is ignored.
